// File: rtl/bp_delta_stream_reader_if.sv
// Delta-stream bundle: start/done, delta RAM read port and the valid/ready delta stream.
// master is the reader side, slave is the RAM/downstream side.
interface bp_delta_stream_reader_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 11
);
    logic                     i_valid;
    logic [ADDRESS_WIDTH-1:0] i_base_addr;
    logic                     o_rd_en;
    logic [ADDRESS_WIDTH-1:0] o_rd_addr;
    logic [DATA_WIDTH-1:0]    i_rd_data;
    logic [DATA_WIDTH-1:0]    o_delta;
    logic [ADDRESS_WIDTH-1:0] o_delta_idx;
    logic                     o_delta_valid;
    logic                     i_delta_ready;
    logic                     o_busy;
    logic                     o_valid;

    modport master (
        input  i_valid, i_base_addr, i_rd_data, i_delta_ready,
        output o_rd_en, o_rd_addr, o_delta, o_delta_idx, o_delta_valid, o_busy, o_valid
    );

    modport slave (
        output i_valid, i_base_addr, i_rd_data, i_delta_ready,
        input  o_rd_en, o_rd_addr, o_delta, o_delta_idx, o_delta_valid, o_busy, o_valid
    );
endinterface

// File: rtl/bp_delta_stream_reader.sv
// Reads NUMBER_OF_OUTPUT_NODE deltas from the delta RAM and streams them over valid/ready.
// Optional: define BP_DELTA_SAT_EN to clamp delta magnitudes (and NaN) to DELTA_LIMIT.
module bp_delta_stream_reader #(
    parameter int unsigned DATA_WIDTH            = 32,
    parameter int unsigned ADDRESS_WIDTH         = 11,
    parameter int unsigned NUMBER_OF_OUTPUT_NODE = 3,
    parameter logic [31:0] DELTA_LIMIT           = 32'h3F800000
) (
    input logic                      clk,
    input logic                      rst,
    bp_delta_stream_reader_if.master bus
);

`ifdef BP_DELTA_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    localparam logic [ADDRESS_WIDTH-1:0] LastIdx = ADDRESS_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [ADDRESS_WIDTH-1:0] rd_cnt_q;
    logic [ADDRESS_WIDTH-1:0] out_cnt_q;
    logic                     inflight_q;
    logic [DATA_WIDTH-1:0]    fifo_q [2];
    logic                     wr_ptr_q, rd_ptr_q;
    logic [1:0]               count_q;

    logic                     start, rd_en, push, pop, last_rd, last_beat, head_valid;
    logic [2:0]               occupancy;
    logic [DATA_WIDTH-1:0]    wdata;

    function automatic logic [DATA_WIDTH-1:0] sat(input logic [DATA_WIDTH-1:0] d);
        logic is_nan;
        is_nan = (d[30:23] == 8'hFF) && (d[22:0] != 23'd0);
        if (is_nan || (d[30:0] > DELTA_LIMIT[30:0])) begin
            return DATA_WIDTH'({d[31], DELTA_LIMIT[30:0]});
        end
        return d;
    endfunction

    assign start      = (state_q == StIdle) && bus.i_valid;
    assign head_valid = (count_q != 2'd0);
    assign push       = inflight_q;
    assign pop        = head_valid && bus.i_delta_ready;

    // Occupancy counts the slot freed by this cycle's pop, so reads keep pace at 1 beat/cycle.
    assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en      = (state_q == StRead) && (occupancy < 3'd2);
    assign last_rd    = rd_en && (rd_cnt_q == LastIdx);
    assign last_beat  = pop && (out_cnt_q == LastIdx);
    assign wdata      = SatEn ? sat(bus.i_rd_data) : bus.i_rd_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.i_valid) state_d = StRead;
            StRead:  if (last_rd)     state_d = StDrain;
            StDrain: if (last_beat)   state_d = StDone;
            StDone:                   state_d = StIdle;
            default:                  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            inflight_q <= rd_en;
            if (start) begin
                base_q    <= bus.i_base_addr;
                rd_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if (rd_en) rd_cnt_q  <= rd_cnt_q + 1'b1;
                if (pop)   out_cnt_q <= out_cnt_q + 1'b1;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= wdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.o_rd_en       = rd_en;
    assign bus.o_rd_addr     = rd_en ? (base_q + rd_cnt_q) : '0;
    assign bus.o_delta_valid = head_valid;
    assign bus.o_delta       = head_valid ? fifo_q[rd_ptr_q] : '0;
    assign bus.o_delta_idx   = head_valid ? out_cnt_q : '0;
    assign bus.o_busy        = (state_q != StIdle);
    assign bus.o_valid       = (state_q == StDone);

endmodule

// File: tb/tb_bp_delta_stream_reader.sv
// Directed, table-driven bench for bp_delta_stream_reader (N=3) with a 1-cycle-latency RAM model.
module tb_bp_delta_stream_reader;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bp_delta_stream_reader_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(11)) bus ();

    bp_delta_stream_reader #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(11), .NUMBER_OF_OUTPUT_NODE(3), .DELTA_LIMIT(32'h3F800000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] ram [2048];

    always @(posedge clk) begin
        if (bus.o_rd_en) bus.i_rd_data <= ram[bus.o_rd_addr];
        else             bus.i_rd_data <= 32'hDEADBEEF;
    end

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: records reads, beats, done pulses and protocol violations per pass.
    int          ncyc = 0, start_cyc = 0, nbeat = 0, nrd = 0, ndone = 0, done_at = -1;
    int          proto_err = 0, max_out = 0;
    logic [31:0] got_d [8];
    logic [10:0] got_i [8];
    logic [10:0] got_a [8];
    int          got_c [8];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic [10:0] prev_i;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.i_valid && !bus.o_busy) begin
                nbeat = 0; nrd = 0; ndone = 0; done_at = -1;
                proto_err = 0; max_out = 0; start_cyc = ncyc; prev_stall = 1'b0;
            end
            if (prev_stall && !(bus.o_delta_valid && bus.o_delta == prev_d &&
                                bus.o_delta_idx == prev_i)) proto_err++;
            if (bus.o_rd_en) begin
                if (nrd < 8) got_a[nrd] = bus.o_rd_addr;
                nrd++;
            end
            if (bus.o_delta_valid && bus.i_delta_ready) begin
                if (nbeat < 8) begin
                    got_d[nbeat] = bus.o_delta;
                    got_i[nbeat] = bus.o_delta_idx;
                    got_c[nbeat] = ncyc - start_cyc;
                end
                nbeat++;
            end
            if (bus.o_valid) begin
                ndone++;
                done_at = ncyc - start_cyc;
                if (!bus.o_busy) proto_err++;
            end
            if (nrd - nbeat > max_out) max_out = nrd - nbeat;
            prev_stall = bus.o_delta_valid && !bus.i_delta_ready;
            prev_d     = bus.o_delta;
            prev_i     = bus.o_delta_idx;
        end
    end

    typedef struct packed {
        logic [10:0]      base;
        logic [2:0][31:0] w;
        logic [15:0]      pat;      // ready per cycle after start, bit 0 = start cycle
        int               repulse;  // cycle offset of a second i_valid pulse, -1 for none
        logic [2:0][31:0] ed;
        logic [2:0][10:0] ea;
        int               edone;    // expected o_valid offset, 0 when ready is throttled
    } vec_t;

    vec_t vecs [6];

`ifdef BP_DELTA_SAT_EN
    localparam logic [31:0] ExpW2 = 32'h3F800000;
    localparam logic [31:0] ExpNeg = 32'hBF800000;
    localparam logic [31:0] ExpNan = 32'h3F800000;
    localparam logic [31:0] ExpInf = 32'h3F800000;
    localparam logic [31:0] ExpNInf = 32'hBF800000;
`else
    localparam logic [31:0] ExpW2 = 32'h40400000;
    localparam logic [31:0] ExpNeg = 32'hC0800000;
    localparam logic [31:0] ExpNan = 32'h7FC00000;
    localparam logic [31:0] ExpInf = 32'h7F800000;
    localparam logic [31:0] ExpNInf = 32'hFF800000;
`endif

    function automatic logic [57:0] all_outs();
        return {bus.o_rd_en, bus.o_rd_addr, bus.o_delta, bus.o_delta_idx,
                bus.o_delta_valid, bus.o_busy, bus.o_valid};
    endfunction

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        for (int k = 0; k < 3; k++) ram[v.base + 11'(k)] = v.w[k];
        @(posedge clk); #1;
        bus.i_base_addr   = v.base;
        bus.i_valid       = 1'b1;
        bus.i_delta_ready = v.pat[0];
        for (int j = 1; j < 40; j++) begin
            @(posedge clk); #1;
            bus.i_valid       = (j == v.repulse);
            bus.i_delta_ready = v.pat[j % 16];
        end
        bus.i_valid = 1'b0;
        chk($sformatf("v%0d_nbeat", i), 32'(nbeat), 32'd3);
        chk($sformatf("v%0d_nrd", i), 32'(nrd), 32'd3);
        chk($sformatf("v%0d_ndone", i), 32'(ndone), 32'd1);
        chk($sformatf("v%0d_proto", i), 32'(proto_err), 32'd0);
        chk($sformatf("v%0d_outstanding_le2", i), 32'(max_out <= 2), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("v%0d_data%0d", i, k), got_d[k], v.ed[k]);
            chk($sformatf("v%0d_idx%0d", i, k), 32'(got_i[k]), 32'(k));
            chk($sformatf("v%0d_addr%0d", i, k), 32'(got_a[k]), 32'(v.ea[k]));
        end
        if (v.edone != 0) begin
            chk($sformatf("v%0d_first_beat_cyc", i), 32'(got_c[0]), 32'd3);
            chk($sformatf("v%0d_done_cyc", i), 32'(done_at), 32'(v.edone));
        end
    endtask

    initial begin
        vecs[0] = '{base: 11'h000, w: {32'h40400000, 32'hBF800000, 32'h3F000000},
                    pat: 16'hFFFF, repulse: -1,
                    ed: {ExpW2, 32'hBF800000, 32'h3F000000},
                    ea: {11'h002, 11'h001, 11'h000}, edone: 6};
        vecs[1] = vecs[0];
        vecs[1].pat = 16'hAAA9;
        vecs[1].edone = 0;
        vecs[2] = '{base: 11'h7FE, w: {32'h33333333, 32'h22222222, 32'h11111111},
                    pat: 16'hFFFF, repulse: -1,
                    ed: {32'h33333333, 32'h22222222, 32'h11111111},
                    ea: {11'h000, 11'h7FF, 11'h7FE}, edone: 6};
        vecs[3] = '{base: 11'h010, w: {32'h7FC00000, 32'hC0800000, 32'h40400000},
                    pat: 16'hFFFF, repulse: -1,
                    ed: {ExpNan, ExpNeg, ExpW2},
                    ea: {11'h012, 11'h011, 11'h010}, edone: 6};
        vecs[4] = '{base: 11'h123, w: {32'h3F800000, 32'hFF800000, 32'h7F800000},
                    pat: 16'hAAAA, repulse: -1,
                    ed: {32'h3F800000, ExpNInf, ExpInf},
                    ea: {11'h125, 11'h124, 11'h123}, edone: 0};
        vecs[5] = vecs[0];
        vecs[5].repulse = 4;

        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_base_addr = '0;
        bus.i_delta_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_zero", 32'(all_outs() == 58'd0), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outs_zero", 32'(all_outs() == 58'd0), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Reset while beat 1 is stalled, then a clean pass.
        ram[0] = 32'h3F000000; ram[1] = 32'hBF800000; ram[2] = 32'h40400000;
        @(posedge clk); #1;
        bus.i_base_addr = 11'h000;
        bus.i_valid = 1'b1;
        bus.i_delta_ready = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
        end
        @(posedge clk); #1;
        bus.i_delta_ready = 1'b0;
        chk("stall_valid", 32'(bus.o_delta_valid), 32'd1);
        chk("stall_idx", 32'(bus.o_delta_idx), 32'd1);
        chk("stall_data", bus.o_delta, 32'hBF800000);
        @(posedge clk); #1;
        chk("stall_hold_data", bus.o_delta, 32'hBF800000);
        rst = 1'b1;
        #1;
        chk("midpass_reset_outs_zero", 32'(all_outs() == 58'd0), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_idle", 32'(all_outs() == 58'd0), 32'd1);
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
